store_data_fifo: RTL and testbench

Store buffer that sits directly downstream of the commit stage. It accepts committed stores on the datafifo interface and holds them in a DEPTH-entry FIFO. It drains them in order as AXI-Lite write transactions to the data memory interconnect, and back-pressures commit through `datafifo_full`. It also provides a pending-store address match so the load path can stall on a read-after-write hazard.

---
 rtl/store_data_fifo.sv | 145 ++++++++++++++
 tb/tb_store_data_fifo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_data_fifo.sv
// Commit-side store buffer: queues committed stores and drains them one at a time
// as AXI-Lite writes, with a pending-address match for load RAW hazard stalls.
module store_data_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] datafifo_addr_in,
  input  logic [31:0] datafifo_val_in,
  input  logic [1:0]  datafifo_size_in,
  input  logic        datafifo_valid_in,
  output logic        datafifo_full,
  output logic        datafifo_empty,
  input  logic [31:0] load_check_addr,
  output logic        load_conflict,
  output logic        store_error,
  output logic [31:0] axil_awaddr,
  output logic        axil_awvalid,
  input  logic        axil_awready,
  output logic [31:0] axil_wdata,
  output logic [3:0]  axil_wstrb,
  output logic        axil_wvalid,
  input  logic        axil_wready,
  input  logic [1:0]  axil_bresp,
  input  logic        axil_bvalid,
  output logic        axil_bready
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
  state_t state, state_next;

  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_val  [DEPTH];
  logic [1:0]    mem_size [DEPTH];
  logic [IW-1:0] slot_off [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, count, count_next;
  logic          aw_done, w_done;
  logic          push, pop, aw_hs, w_hs;
  logic [31:0]   head_addr, head_val;
  logic [1:0]    head_size;
  logic          unused_bits;

  assign datafifo_full  = (count == PW'(DEPTH));
  assign datafifo_empty = (count == '0) && (state == IDLE);
  assign push  = datafifo_valid_in && !datafifo_full;
  assign pop   = (state == RESP) && axil_bvalid;
  assign aw_hs = axil_awvalid && axil_awready;
  assign w_hs  = axil_wvalid && axil_wready;

  assign head_addr = mem_addr[rd_ptr[IW-1:0]];
  assign head_val  = mem_val[rd_ptr[IW-1:0]];
  assign head_size = mem_size[rd_ptr[IW-1:0]];
  assign unused_bits = ^{load_check_addr[1:0], wr_ptr[IW], rd_ptr[IW]};

  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array has no reset; occupancy is tracked purely by pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr[IW-1:0]] <= datafifo_addr_in;
      mem_val[wr_ptr[IW-1:0]]  <= datafifo_val_in;
      mem_size[wr_ptr[IW-1:0]] <= datafifo_size_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      store_error <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      store_error <= pop && (axil_bresp != 2'b00);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == SEND) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (count != '0) state_next = SEND;
      SEND: if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = RESP;
      RESP: if (axil_bvalid) state_next = (count_next != '0) ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Head entry is presented lane-formatted whenever a transaction is in progress.
  always_comb begin
    axil_awaddr  = '0;
    axil_wdata   = '0;
    axil_wstrb   = '0;
    if (state != IDLE) begin
      axil_awaddr = {head_addr[31:2], 2'b00};
      case (head_size)
        2'd0: begin
          axil_wstrb = 4'b0001 << head_addr[1:0];
          axil_wdata = {4{head_val[7:0]}};
        end
        2'd1: begin
          axil_wstrb = head_addr[1] ? 4'b1100 : 4'b0011;
          axil_wdata = {2{head_val[15:0]}};
        end
        default: begin
          axil_wstrb = 4'b1111;
          axil_wdata = head_val;
        end
      endcase
    end
    axil_awvalid = (state == SEND) && !aw_done;
    axil_wvalid  = (state == SEND) && !w_done;
    axil_bready  = (state == RESP);
  end

  always_comb begin
    load_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i] = IW'(i) - rd_ptr[IW-1:0];
      if (({1'b0, slot_off[i]} < count) && (mem_addr[i][31:2] == load_check_addr[31:2]))
        load_conflict = 1'b1;
    end
  end
endmodule

// File: tb/tb_store_data_fifo.sv
// Randomized bench for store_data_fifo: a queue of pending stores is the reference,
// and the bench plays the AXI-Lite slave with random ready/response timing.
module tb_store_data_fifo;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] val;
    logic [1:0]  size;
  } store_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] datafifo_addr_in, datafifo_val_in;
  logic [1:0]  datafifo_size_in;
  logic        datafifo_valid_in, datafifo_full, datafifo_empty;
  logic [31:0] load_check_addr;
  logic        load_conflict, store_error;
  logic [31:0] axil_awaddr, axil_wdata;
  logic        axil_awvalid, axil_awready, axil_wvalid, axil_wready;
  logic [3:0]  axil_wstrb;
  logic [1:0]  axil_bresp;
  logic        axil_bvalid, axil_bready;

  always #5 clk = ~clk;

  store_data_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .datafifo_addr_in(datafifo_addr_in), .datafifo_val_in(datafifo_val_in),
    .datafifo_size_in(datafifo_size_in), .datafifo_valid_in(datafifo_valid_in),
    .datafifo_full(datafifo_full), .datafifo_empty(datafifo_empty),
    .load_check_addr(load_check_addr), .load_conflict(load_conflict),
    .store_error(store_error),
    .axil_awaddr(axil_awaddr), .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
    .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb), .axil_wvalid(axil_wvalid),
    .axil_wready(axil_wready), .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid),
    .axil_bready(axil_bready)
  );

  store_t pend[$];
  store_t stim_q[$];
  int compared = 0;
  int mismatched = 0;
  int err_pulses = 0;
  int pct_push, pct_aw, pct_w, pct_b, pct_err;
  logic aw_seen, w_seen, exp_err;
  logic prev_aw_wait, prev_w_wait;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [3:0]  prev_wstrb;
  logic        load_ovr_en;
  logic [31:0] load_ovr;
  logic        s_awvalid, s_wvalid, s_bready, s_conflict, s_full, s_empty;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic store_t rand_store();
    store_t s;
    s.size = 2'($urandom_range(3));
    s.addr = 32'h4000 + 32'($urandom_range(63));
    if (s.size == 2'd1) s.addr[0] = 1'b0;
    else if (s.size != 2'd0) s.addr[1:0] = 2'b00;
    s.val = $urandom;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input store_t s);
    if (s.size == 2'd0) return 32'(s.val[7:0]) * 32'h0101_0101;
    if (s.size == 2'd1) return 32'(s.val[15:0]) * 32'h0001_0001;
    return s.val;
  endfunction

  function automatic logic [3:0] exp_wstrb(input store_t s);
    int lane = int'(s.addr[1:0]);
    if (s.size == 2'd0) return 4'(1 << lane);
    if (s.size == 2'd1) return 4'(3 << ((lane / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic model_conflict(input logic [31:0] a);
    foreach (pend[i]) if ((pend[i].addr >> 2) == (a >> 2)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clearModel();
    pend.delete();
    stim_q.delete();
    aw_seen = 1'b0; w_seen = 1'b0; exp_err = 1'b0;
    prev_aw_wait = 1'b0; prev_w_wait = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    store_t s;
    logic push, hs_aw, hs_w, hs_b;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      push = 1'b0;
      s = rand_store();
      if (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        push = 1'b1;
      end else if (pend.size() < DEPTH && $urandom_range(99) < pct_push) begin
        push = 1'b1;
      end
      datafifo_valid_in = push;
      datafifo_addr_in  = s.addr;
      datafifo_val_in   = s.val;
      datafifo_size_in  = s.size;
      axil_awready = ($urandom_range(99) < pct_aw);
      axil_wready  = ($urandom_range(99) < pct_w);
      axil_bvalid  = aw_seen && w_seen && ($urandom_range(99) < pct_b);
      axil_bresp   = ($urandom_range(99) < pct_err) ? 2'($urandom_range(3, 1)) : 2'b00;
      if (load_ovr_en) load_check_addr = load_ovr;
      else if (pend.size() > 0 && $urandom_range(1) == 1)
        load_check_addr = pend[$urandom_range(pend.size() - 1)].addr ^ 32'($urandom_range(7));
      else load_check_addr = rand_store().addr;
      #1;
      checkOutput("full", datafifo_full, pend.size() == DEPTH);
      checkOutput("empty", datafifo_empty, pend.size() == 0);
      checkOutput("conflict", load_conflict, model_conflict(load_check_addr));
      checkOutput("store_error", store_error, exp_err);
      checkOutput("bready", axil_bready, aw_seen && w_seen);
      if (pend.size() == 0) begin
        checkOutput("aw_idle", axil_awvalid, 1'b0);
        checkOutput("w_idle", axil_wvalid, 1'b0);
      end
      if (aw_seen) checkOutput("aw_once", axil_awvalid, 1'b0);
      if (w_seen)  checkOutput("w_once", axil_wvalid, 1'b0);
      if (prev_aw_wait) begin
        checkOutput("aw_hold", axil_awvalid, 1'b1);
        checkOutput("aw_stable", axil_awaddr, prev_awaddr);
      end
      if (prev_w_wait) begin
        checkOutput("w_hold", axil_wvalid, 1'b1);
        checkOutput("wdata_stable", axil_wdata, prev_wdata);
        checkOutput("wstrb_stable", 32'(axil_wstrb), 32'(prev_wstrb));
      end
      hs_aw = axil_awvalid && axil_awready;
      hs_w  = axil_wvalid && axil_wready;
      hs_b  = axil_bvalid && axil_bready;
      if (hs_aw && pend.size() > 0)
        checkOutput("awaddr", axil_awaddr, pend[0].addr & 32'hFFFF_FFFC);
      if (hs_w && pend.size() > 0) begin
        checkOutput("wdata", axil_wdata, exp_wdata(pend[0]));
        checkOutput("wstrb", 32'(axil_wstrb), 32'(exp_wstrb(pend[0])));
      end
      if (store_error) err_pulses++;
      s_awvalid = axil_awvalid; s_wvalid = axil_wvalid; s_bready = axil_bready;
      s_awaddr = axil_awaddr; s_wdata = axil_wdata; s_wstrb = axil_wstrb;
      s_conflict = load_conflict; s_full = datafifo_full; s_empty = datafifo_empty;
      prev_aw_wait = axil_awvalid && !axil_awready; prev_awaddr = axil_awaddr;
      prev_w_wait  = axil_wvalid && !axil_wready;
      prev_wdata = axil_wdata; prev_wstrb = axil_wstrb;
      @(posedge clk);
      exp_err = hs_b && (axil_bresp != 2'b00);
      if (hs_aw) aw_seen = 1'b1;
      if (hs_w)  w_seen = 1'b1;
      push = push && (pend.size() < DEPTH);
      if (hs_b && pend.size() > 0) begin
        void'(pend.pop_front());
        aw_seen = 1'b0; w_seen = 1'b0;
      end
      if (push) pend.push_back(s);
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    datafifo_valid_in = 1'b0; datafifo_addr_in = '0; datafifo_val_in = '0; datafifo_size_in = '0;
    axil_awready = 1'b0; axil_wready = 1'b0; axil_bvalid = 1'b0; axil_bresp = '0;
    load_check_addr = '0;
    clearModel();
    repeat (2) @(negedge clk);
    checkOutput("rst_awvalid", axil_awvalid, 1'b0);
    checkOutput("rst_wvalid", axil_wvalid, 1'b0);
    checkOutput("rst_bready", axil_bready, 1'b0);
    checkOutput("rst_store_error", store_error, 1'b0);
    checkOutput("rst_awaddr", axil_awaddr, 32'h0);
    checkOutput("rst_wdata", axil_wdata, 32'h0);
    checkOutput("rst_wstrb", 32'(axil_wstrb), 32'h0);
    checkOutput("rst_full", datafifo_full, 1'b0);
    checkOutput("rst_empty", datafifo_empty, 1'b1);
    reset = 1'b1;
  endtask

  task automatic directedStore(input string tag, input logic [31:0] addr, input logic [31:0] val,
                               input logic [1:0] size, input logic [31:0] exp_addr,
                               input logic [31:0] exp_data, input logic [3:0] exp_strb);
    store_t s;
    s.addr = addr; s.val = val; s.size = size;
    pct_push = 0; pct_aw = 100; pct_w = 100; pct_b = 100; pct_err = 0;
    stim_q.push_back(s);
    applyStimulus(2);
    checkOutput({tag, "_lat_idle"}, s_awvalid, 1'b0);
    applyStimulus(1);
    checkOutput({tag, "_lat_send"}, s_awvalid, 1'b1);
    checkOutput({tag, "_awaddr"}, s_awaddr, exp_addr);
    checkOutput({tag, "_wdata"}, s_wdata, exp_data);
    checkOutput({tag, "_wstrb"}, 32'(s_wstrb), 32'(exp_strb));
    applyStimulus(2);
    checkOutput({tag, "_empty"}, s_empty, 1'b1);
  endtask

  initial begin
    load_ovr_en = 1'b0; load_ovr = '0;
    pct_push = 0; pct_aw = 100; pct_w = 100; pct_b = 100; pct_err = 0;
    doReset();

    directedStore("word", 32'h1000, 32'hDEAD_BEEF, 2'd2, 32'h1000, 32'hDEAD_BEEF, 4'hF);
    directedStore("byte", 32'h2003, 32'h0000_00AB, 2'd0, 32'h2000, 32'hABAB_ABAB, 4'b1000);
    directedStore("half", 32'h2002, 32'h0000_1234, 2'd1, 32'h2000, 32'h1234_1234, 4'b1100);

    $display("[TB] fill and back-pressure");
    pct_aw = 0;
    for (int i = 0; i < 4; i++) stim_q.push_back(rand_store());
    applyStimulus(5);
    checkOutput("fill_full", s_full, 1'b1);
    stim_q.push_back(rand_store());
    applyStimulus(2);
    checkOutput("fill_still_full", s_full, 1'b1);
    pct_aw = 100;
    applyStimulus(16);
    checkOutput("fill_drained", s_empty, 1'b1);

    $display("[TB] channel skew");
    pct_aw = 0;
    stim_q.push_back(rand_store());
    applyStimulus(4);
    checkOutput("skew_w_dropped", s_wvalid, 1'b0);
    checkOutput("skew_bready_low", s_bready, 1'b0);
    pct_aw = 100;
    applyStimulus(4);
    checkOutput("skew_empty", s_empty, 1'b1);

    $display("[TB] conflict and error");
    pct_aw = 0; pct_w = 0;
    stim_q.push_back('{addr: 32'h3004, val: 32'h5555_AAAA, size: 2'd2});
    applyStimulus(3);
    load_ovr_en = 1'b1; load_ovr = 32'h3007;
    applyStimulus(1);
    checkOutput("conf_hit", s_conflict, 1'b1);
    load_ovr = 32'h3008;
    applyStimulus(1);
    checkOutput("conf_miss", s_conflict, 1'b0);
    load_ovr_en = 1'b0;
    err_pulses = 0;
    pct_aw = 100; pct_w = 100; pct_b = 100; pct_err = 100;
    applyStimulus(5);
    checkOutput("err_pulses", err_pulses, 1);
    checkOutput("err_popped", s_empty, 1'b1);

    $display("[TB] random traffic");
    pct_push = 40; pct_aw = 60; pct_w = 60; pct_b = 50; pct_err = 10;
    applyStimulus(2000);
    pct_push = 0; pct_aw = 100; pct_w = 100; pct_b = 100; pct_err = 0;
    for (int i = 0; i < 100 && pend.size() > 0; i++) applyStimulus(1);
    applyStimulus(1);
    checkOutput("drain_empty", s_empty, 1'b1);

    $display("[TB] reset mid-operation");
    pct_aw = 0; pct_w = 0;
    for (int i = 0; i < 3; i++) stim_q.push_back(rand_store());
    applyStimulus(5);
    checkOutput("midrst_sending", s_awvalid, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_awvalid", axil_awvalid, 1'b0);
    checkOutput("midrst_wvalid", axil_wvalid, 1'b0);
    checkOutput("midrst_bready", axil_bready, 1'b0);
    checkOutput("midrst_empty", datafifo_empty, 1'b1);
    datafifo_valid_in = 1'b0;
    clearModel();
    @(negedge clk);
    reset = 1'b1;
    pct_aw = 100; pct_w = 100;
    applyStimulus(10);
    checkOutput("postrst_empty", s_empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
